// File: rtl/cpu_ctrl_pkg.sv
// Shared opcode constants, sequencer state and opcode-class types for the CPU control unit.
package cpu_ctrl_pkg;

    localparam logic [4:0] OPC_LD   = 5'b00000;
    localparam logic [4:0] OPC_LDI  = 5'b00001;
    localparam logic [4:0] OPC_ST   = 5'b00010;
    localparam logic [4:0] OPC_ADD  = 5'b00011;
    localparam logic [4:0] OPC_SUB  = 5'b00100;
    localparam logic [4:0] OPC_AND  = 5'b00101;
    localparam logic [4:0] OPC_OR   = 5'b00110;
    localparam logic [4:0] OPC_SHR  = 5'b00111;
    localparam logic [4:0] OPC_SHL  = 5'b01000;
    localparam logic [4:0] OPC_ROR  = 5'b01001;
    localparam logic [4:0] OPC_ROL  = 5'b01010;
    localparam logic [4:0] OPC_ADDI = 5'b01011;
    localparam logic [4:0] OPC_ANDI = 5'b01100;
    localparam logic [4:0] OPC_ORI  = 5'b01101;
    localparam logic [4:0] OPC_MUL  = 5'b01110;
    localparam logic [4:0] OPC_DIV  = 5'b01111;
    localparam logic [4:0] OPC_NEG  = 5'b10000;
    localparam logic [4:0] OPC_NOT  = 5'b10001;
    localparam logic [4:0] OPC_BR   = 5'b10010;
    localparam logic [4:0] OPC_JR   = 5'b10011;
    localparam logic [4:0] OPC_IN   = 5'b10100;
    localparam logic [4:0] OPC_OUT  = 5'b10101;
    localparam logic [4:0] OPC_MFHI = 5'b10110;
    localparam logic [4:0] OPC_MFLO = 5'b10111;
    localparam logic [4:0] OPC_NOP  = 5'b11000;
    localparam logic [4:0] OPC_HALT = 5'b11001;

    // Address arithmetic (ld/ldi/st/br) always uses the ALU add.
    localparam logic [4:0] OP_ADD = OPC_ADD;

    typedef enum logic [3:0] {
        S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_PAUSE, S_HALT
    } state_e;

    typedef enum logic [3:0] {
        CL_ALU_REG, CL_ALU_IMM, CL_MULDIV, CL_UNARY, CL_LD, CL_LDI, CL_ST, CL_BR,
        CL_JR, CL_IN, CL_OUT, CL_MFHI, CL_MFLO, CL_NOP, CL_HALT
    } op_class_e;

    // Final execute step of each class; the sequencer returns to T0 after it.
    function automatic state_e last_step(input op_class_e cls);
        case (cls)
            CL_ALU_REG, CL_ALU_IMM, CL_LDI: last_step = S_T5;
            CL_MULDIV, CL_BR:               last_step = S_T6;
            CL_UNARY:                       last_step = S_T4;
            CL_LD, CL_ST:                   last_step = S_T7;
            default:                        last_step = S_T3;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_op_decode.sv
// Combinational opcode-to-class decoder; undefined opcodes fall into the nop class.
module ctrl_op_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [4:0] opcode,
    output op_class_e  op_class
);

    always_comb begin
        op_class = CL_NOP;
        case (opcode)
            OPC_ADD, OPC_SUB, OPC_AND, OPC_OR,
            OPC_SHR, OPC_SHL, OPC_ROR, OPC_ROL: op_class = CL_ALU_REG;
            OPC_ADDI, OPC_ANDI, OPC_ORI:        op_class = CL_ALU_IMM;
            OPC_MUL, OPC_DIV:                   op_class = CL_MULDIV;
            OPC_NEG, OPC_NOT:                   op_class = CL_UNARY;
            OPC_LD:                             op_class = CL_LD;
            OPC_LDI:                            op_class = CL_LDI;
            OPC_ST:                             op_class = CL_ST;
            OPC_BR:                             op_class = CL_BR;
            OPC_JR:                             op_class = CL_JR;
            OPC_IN:                             op_class = CL_IN;
            OPC_OUT:                            op_class = CL_OUT;
            OPC_MFHI:                           op_class = CL_MFHI;
            OPC_MFLO:                           op_class = CL_MFLO;
            OPC_HALT:                           op_class = CL_HALT;
            default:                            op_class = CL_NOP;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Moore-style hardwired sequencer: fetch T0-T2, per-class execute T3-T7, pause and halt handling.
module control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned OPW           = 6,
    parameter int unsigned RESET_PC_WAIT = 1
) (
    input  logic           clk,
    input  logic           clr,
    input  logic           stop,
    input  logic [31:0]    ir,
    input  logic           con_ff,
    output logic           run,
    output logic           gra,
    output logic           grb,
    output logic           grc,
    output logic           r_in,
    output logic           r_out,
    output logic           ba_out,
    output logic           pc_out,
    output logic           mdr_out,
    output logic           zhigh_out,
    output logic           zlow_out,
    output logic           hi_out,
    output logic           lo_out,
    output logic           inport_out,
    output logic           c_out,
    output logic           mar_in,
    output logic           pc_in,
    output logic           mdr_in,
    output logic           ir_in,
    output logic           y_in,
    output logic           hi_in,
    output logic           lo_in,
    output logic           zhigh_in,
    output logic           zlow_in,
    output logic           outport_in,
    output logic           con_in,
    output logic           inc_pc,
    output logic           read,
    output logic           write,
    output logic [OPW-1:0] operation
);

    localparam logic [2:0] WAIT_LAST = 3'(RESET_PC_WAIT - 1);

    state_e     state_q, state_d, t0_entry;
    logic [2:0] wait_q, wait_d;
    op_class_e  op_class;
    logic [4:0] opcode;
    logic [OPW-1:0] op_alu, op_add;
    logic       unused_ir;

    assign opcode    = ir[31:27];
    assign op_alu    = OPW'(opcode);
    assign op_add    = OPW'(OP_ADD);
    assign unused_ir = ^ir[26:0];

    ctrl_op_decode u_decode (
        .opcode   (opcode),
        .op_class (op_class)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= S_RESET;
            wait_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // stop is only honoured on entry to T0, so an in-flight instruction always completes.
    assign t0_entry = stop ? S_PAUSE : S_T0;

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            S_RESET: begin
                if (wait_q == WAIT_LAST) begin
                    wait_d  = 3'd0;
                    state_d = t0_entry;
                end else begin
                    wait_d = wait_q + 3'd1;
                end
            end
            S_T0:    state_d = S_T1;
            S_T1:    state_d = S_T2;
            // Class is decided here so nop returns to T0 without a dead T3.
            S_T2: begin
                case (op_class)
                    CL_NOP:  state_d = t0_entry;
                    CL_HALT: state_d = S_HALT;
                    default: state_d = S_T3;
                endcase
            end
            S_T3, S_T4, S_T5, S_T6, S_T7: begin
                if (state_q == last_step(op_class)) state_d = t0_entry;
                else                                state_d = state_e'(state_q + 4'd1);
            end
            S_PAUSE: if (!stop) state_d = S_T0;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_RESET;
        endcase
    end

    always_comb begin
        {gra, grb, grc, r_in, r_out, ba_out} = '0;
        {pc_out, mdr_out, zhigh_out, zlow_out, hi_out, lo_out, inport_out, c_out} = '0;
        {mar_in, pc_in, mdr_in, ir_in, y_in, hi_in, lo_in, zhigh_in, zlow_in} = '0;
        {outport_in, con_in, inc_pc, read, write} = '0;
        operation = '0;
        run       = 1'b0;
        case (state_q)
            S_T0: begin
                run = 1'b1;
                pc_out = 1'b1; mar_in = 1'b1; inc_pc = 1'b1; zlow_in = 1'b1;
            end
            S_T1: begin
                run = 1'b1;
                zlow_out = 1'b1; pc_in = 1'b1; read = 1'b1; mdr_in = 1'b1;
            end
            S_T2: begin
                run = 1'b1;
                mdr_out = 1'b1; ir_in = 1'b1;
            end
            S_T3: begin
                run = 1'b1;
                case (op_class)
                    CL_ALU_REG, CL_ALU_IMM: begin grb = 1'b1; r_out = 1'b1; y_in = 1'b1; end
                    CL_MULDIV: begin gra = 1'b1; r_out = 1'b1; y_in = 1'b1; end
                    CL_UNARY: begin
                        grb = 1'b1; r_out = 1'b1; zlow_in = 1'b1; operation = op_alu;
                    end
                    CL_LD, CL_LDI, CL_ST: begin grb = 1'b1; ba_out = 1'b1; y_in = 1'b1; end
                    CL_BR:   begin gra = 1'b1; r_out = 1'b1; con_in = 1'b1; end
                    CL_JR:   begin gra = 1'b1; r_out = 1'b1; pc_in = 1'b1; end
                    CL_IN:   begin inport_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
                    CL_OUT:  begin gra = 1'b1; r_out = 1'b1; outport_in = 1'b1; end
                    CL_MFHI: begin hi_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
                    CL_MFLO: begin lo_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
                    default: ;
                endcase
            end
            S_T4: begin
                run = 1'b1;
                case (op_class)
                    CL_ALU_REG: begin
                        grc = 1'b1; r_out = 1'b1; zlow_in = 1'b1; operation = op_alu;
                    end
                    CL_ALU_IMM: begin c_out = 1'b1; zlow_in = 1'b1; operation = op_alu; end
                    CL_MULDIV: begin
                        grb = 1'b1; r_out = 1'b1; zlow_in = 1'b1; zhigh_in = 1'b1;
                        operation = op_alu;
                    end
                    CL_UNARY: begin zlow_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
                    CL_LD, CL_LDI, CL_ST: begin
                        c_out = 1'b1; zlow_in = 1'b1; operation = op_add;
                    end
                    CL_BR:   begin pc_out = 1'b1; y_in = 1'b1; end
                    default: ;
                endcase
            end
            S_T5: begin
                run = 1'b1;
                case (op_class)
                    CL_ALU_REG, CL_ALU_IMM, CL_LDI: begin
                        zlow_out = 1'b1; gra = 1'b1; r_in = 1'b1;
                    end
                    CL_MULDIV:    begin zlow_out = 1'b1; lo_in = 1'b1; end
                    CL_LD, CL_ST: begin zlow_out = 1'b1; mar_in = 1'b1; end
                    CL_BR: begin c_out = 1'b1; zlow_in = 1'b1; operation = op_add; end
                    default: ;
                endcase
            end
            S_T6: begin
                run = 1'b1;
                case (op_class)
                    CL_MULDIV: begin zhigh_out = 1'b1; hi_in = 1'b1; end
                    CL_LD:     begin read = 1'b1; mdr_in = 1'b1; end
                    CL_ST:     begin gra = 1'b1; r_out = 1'b1; mdr_in = 1'b1; end
                    // Branch not taken leaves a dead cycle so br timing is fixed.
                    CL_BR:     begin zlow_out = con_ff; pc_in = con_ff; end
                    default: ;
                endcase
            end
            S_T7: begin
                run = 1'b1;
                case (op_class)
                    CL_LD:   begin mdr_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
                    CL_ST:   write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed-vector bench for control_unit: checks every strobe, operation and run each cycle.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        clr, stop, con_ff;
    logic [31:0] ir;
    logic        run, gra, grb, grc, r_in, r_out, ba_out, pc_out, mdr_out, zhigh_out, zlow_out;
    logic        hi_out, lo_out, inport_out, c_out, mar_in, pc_in, mdr_in, ir_in, y_in, hi_in;
    logic        lo_in, zhigh_in, zlow_in, outport_in, con_in, inc_pc, read, write;
    logic [5:0]  operation;
    logic [27:0] strobes;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [27:0] GRA = 28'd1 << 27, GRB = 28'd1 << 26, GRC = 28'd1 << 25;
    localparam logic [27:0] R_IN = 28'd1 << 24, R_OUT = 28'd1 << 23, BA_OUT = 28'd1 << 22;
    localparam logic [27:0] PC_OUT = 28'd1 << 21, MDR_OUT = 28'd1 << 20;
    localparam logic [27:0] ZHIGH_OUT = 28'd1 << 19, ZLOW_OUT = 28'd1 << 18;
    localparam logic [27:0] HI_OUT = 28'd1 << 17, LO_OUT = 28'd1 << 16;
    localparam logic [27:0] INPORT_OUT = 28'd1 << 15, C_OUT = 28'd1 << 14;
    localparam logic [27:0] MAR_IN = 28'd1 << 13, PC_IN = 28'd1 << 12, MDR_IN = 28'd1 << 11;
    localparam logic [27:0] IR_IN = 28'd1 << 10, Y_IN = 28'd1 << 9, HI_IN = 28'd1 << 8;
    localparam logic [27:0] LO_IN = 28'd1 << 7, ZHIGH_IN = 28'd1 << 6, ZLOW_IN = 28'd1 << 5;
    localparam logic [27:0] OUTPORT_IN = 28'd1 << 4, CON_IN = 28'd1 << 3;
    localparam logic [27:0] INC_PC = 28'd1 << 2, READ = 28'd1 << 1, WRITE = 28'd1;

    localparam logic [27:0] F0 = PC_OUT | MAR_IN | INC_PC | ZLOW_IN;
    localparam logic [27:0] F1 = ZLOW_OUT | PC_IN | READ | MDR_IN;
    localparam logic [27:0] F2 = MDR_OUT | IR_IN;

    assign strobes = {gra, grb, grc, r_in, r_out, ba_out, pc_out, mdr_out, zhigh_out, zlow_out,
                      hi_out, lo_out, inport_out, c_out, mar_in, pc_in, mdr_in, ir_in, y_in,
                      hi_in, lo_in, zhigh_in, zlow_in, outport_in, con_in, inc_pc, read, write};

    always #5 clk = ~clk;

    control_unit #(.OPW(6), .RESET_PC_WAIT(1)) dut (
        .clk(clk), .clr(clr), .stop(stop), .ir(ir), .con_ff(con_ff), .run(run),
        .gra(gra), .grb(grb), .grc(grc), .r_in(r_in), .r_out(r_out), .ba_out(ba_out),
        .pc_out(pc_out), .mdr_out(mdr_out), .zhigh_out(zhigh_out), .zlow_out(zlow_out),
        .hi_out(hi_out), .lo_out(lo_out), .inport_out(inport_out), .c_out(c_out),
        .mar_in(mar_in), .pc_in(pc_in), .mdr_in(mdr_in), .ir_in(ir_in), .y_in(y_in),
        .hi_in(hi_in), .lo_in(lo_in), .zhigh_in(zhigh_in), .zlow_in(zlow_in),
        .outport_in(outport_in), .con_in(con_in), .inc_pc(inc_pc), .read(read),
        .write(write), .operation(operation)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        clr = 1'b0; stop = 1'b0; con_ff = 1'b0; ir = 32'hC000_0000;
        tick(); tick();
        n_vec++;
        if (strobes !== 28'd0 || run !== 1'b0 || operation !== 6'd0) begin
            n_err++;
            $display("FAIL reset_hold: strobes=%h run=%b op=%h, need 0/0/0", strobes, run, operation);
        end
        clr = 1'b1;
        #1;
        n_vec++;
        if (strobes !== 28'd0 || run !== 1'b0) begin
            n_err++;
            $display("FAIL reset_wait: strobes=%h run=%b, need 0/0", strobes, run);
        end
        tick();
        n_vec++;
        if (strobes !== F0 || run !== 1'b1) begin
            n_err++;
            $display("FAIL reset_first_t0: strobes=%h run=%b, need %h/1", strobes, run, F0);
        end
    endtask

    // Entered and left with the DUT in T0; each row runs T0 through its last step and back to T0.
    task automatic test_sequences;
        logic [31:0] iv [12];
        int          ln [12];
        logic [27:0] es [12][8];
        logic [5:0]  eo [12][8];
        logic [27:0] exp_s;
        for (int i = 0; i < 12; i++)
            for (int k = 0; k < 8; k++) begin es[i][k] = '0; eo[i][k] = '0; end
        iv[0] = 32'h18A0_0000; ln[0] = 6;   // add
        es[0][3] = GRB | R_OUT | Y_IN; es[0][4] = GRC | R_OUT | ZLOW_IN; eo[0][4] = 6'h03;
        es[0][5] = ZLOW_OUT | GRA | R_IN;
        iv[1] = 32'h5800_0000; ln[1] = 6;   // addi
        es[1][3] = GRB | R_OUT | Y_IN; es[1][4] = C_OUT | ZLOW_IN; eo[1][4] = 6'h0B;
        es[1][5] = ZLOW_OUT | GRA | R_IN;
        iv[2] = 32'h0000_0000; ln[2] = 8;   // ld
        es[2][3] = GRB | BA_OUT | Y_IN; es[2][4] = C_OUT | ZLOW_IN; eo[2][4] = 6'h03;
        es[2][5] = ZLOW_OUT | MAR_IN; es[2][6] = READ | MDR_IN; es[2][7] = MDR_OUT | GRA | R_IN;
        iv[3] = 32'h1000_0000; ln[3] = 8;   // st
        es[3][3] = GRB | BA_OUT | Y_IN; es[3][4] = C_OUT | ZLOW_IN; eo[3][4] = 6'h03;
        es[3][5] = ZLOW_OUT | MAR_IN; es[3][6] = GRA | R_OUT | MDR_IN; es[3][7] = WRITE;
        iv[4] = 32'h8000_0000; ln[4] = 5;   // neg
        es[4][3] = GRB | R_OUT | ZLOW_IN; eo[4][3] = 6'h10; es[4][4] = ZLOW_OUT | GRA | R_IN;
        iv[5] = 32'h9800_0000; ln[5] = 4;   // jr
        es[5][3] = GRA | R_OUT | PC_IN;
        iv[6] = 32'hA000_0000; ln[6] = 4;   // in
        es[6][3] = INPORT_OUT | GRA | R_IN;
        iv[7] = 32'hB000_0000; ln[7] = 4;   // mfhi
        es[7][3] = HI_OUT | GRA | R_IN;
        iv[8] = 32'hC000_0000; ln[8] = 3;   // nop
        iv[9] = 32'hF800_0000; ln[9] = 3;   // undefined opcode 11111
        iv[10] = 32'h0800_0000; ln[10] = 6; // ldi
        es[10][3] = GRB | BA_OUT | Y_IN; es[10][4] = C_OUT | ZLOW_IN; eo[10][4] = 6'h03;
        es[10][5] = ZLOW_OUT | GRA | R_IN;
        iv[11] = 32'h7800_0000; ln[11] = 7; // div
        es[11][3] = GRA | R_OUT | Y_IN; es[11][4] = GRB | R_OUT | ZLOW_IN | ZHIGH_IN;
        eo[11][4] = 6'h0F; es[11][5] = ZLOW_OUT | LO_IN; es[11][6] = ZHIGH_OUT | HI_IN;
        for (int i = 0; i < 12; i++) begin
            ir = iv[i];
            for (int k = 0; k < ln[i]; k++) begin
                exp_s = (k == 0) ? F0 : (k == 1) ? F1 : (k == 2) ? F2 : es[i][k];
                n_vec++;
                if (strobes !== exp_s || operation !== eo[i][k] || run !== 1'b1) begin
                    n_err++;
                    $display("FAIL seq[%0d] T%0d: strobes=%h op=%h run=%b, need %h/%h/1",
                             i, k, strobes, operation, run, exp_s, eo[i][k]);
                end
                tick();
            end
            n_vec++;
            if (strobes !== F0) begin
                n_err++;
                $display("FAIL seq[%0d] latency: strobes=%h after %0d cycles, need %h",
                         i, strobes, ln[i], F0);
            end
        end
    endtask

    task automatic test_branch;
        logic [27:0] es [7];
        logic [5:0]  eo [7];
        for (int c = 0; c < 2; c++) begin
            con_ff = c[0];
            ir = 32'h9000_0000;
            es[0] = F0; es[1] = F1; es[2] = F2; es[3] = GRA | R_OUT | CON_IN;
            es[4] = PC_OUT | Y_IN; es[5] = C_OUT | ZLOW_IN; es[6] = c[0] ? (ZLOW_OUT | PC_IN) : '0;
            for (int k = 0; k < 7; k++) eo[k] = (k == 5) ? 6'h03 : 6'h00;
            for (int k = 0; k < 7; k++) begin
                n_vec++;
                if (strobes !== es[k] || operation !== eo[k] || run !== 1'b1) begin
                    n_err++;
                    $display("FAIL br con=%0d T%0d: strobes=%h op=%h run=%b, need %h/%h/1",
                             c, k, strobes, operation, run, es[k], eo[k]);
                end
                tick();
            end
            n_vec++;
            if (strobes !== F0) begin
                n_err++;
                $display("FAIL br con=%0d latency: strobes=%h, need %h", c, strobes, F0);
            end
        end
        con_ff = 1'b0;
    endtask

    task automatic test_reset_mid;
        ir = 32'h18A0_0000;
        for (int k = 0; k < 4; k++) tick();
        n_vec++;
        if (operation !== 6'h03 || strobes !== (GRC | R_OUT | ZLOW_IN)) begin
            n_err++;
            $display("FAIL mid_t4: strobes=%h op=%h, need %h/03",
                     strobes, operation, GRC | R_OUT | ZLOW_IN);
        end
        clr = 1'b0;
        #1;
        n_vec++;
        if (strobes !== 28'd0 || run !== 1'b0 || operation !== 6'd0) begin
            n_err++;
            $display("FAIL mid_async_clr: strobes=%h run=%b op=%h, need 0", strobes, run, operation);
        end
        tick(); tick();
        clr = 1'b1;
        #1;
        n_vec++;
        if (strobes !== 28'd0 || run !== 1'b0) begin
            n_err++;
            $display("FAIL mid_release: strobes=%h run=%b, need 0/0", strobes, run);
        end
        tick();
        n_vec++;
        if (strobes !== F0 || run !== 1'b1) begin
            n_err++;
            $display("FAIL mid_restart: strobes=%h run=%b, need %h/1", strobes, run, F0);
        end
    endtask

    task automatic test_stop_mul;
        ir = 32'h7000_0000;
        for (int k = 0; k < 4; k++) tick();
        stop = 1'b1;
        tick();
        n_vec++;
        if (strobes !== (ZLOW_OUT | LO_IN) || run !== 1'b1) begin
            n_err++;
            $display("FAIL stop_t5: strobes=%h run=%b, need %h/1", strobes, run, ZLOW_OUT | LO_IN);
        end
        tick();
        n_vec++;
        if (strobes !== (ZHIGH_OUT | HI_IN) || run !== 1'b1) begin
            n_err++;
            $display("FAIL stop_t6: strobes=%h run=%b, need %h/1", strobes, run, ZHIGH_OUT | HI_IN);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_vec++;
            if (strobes !== 28'd0 || run !== 1'b0) begin
                n_err++;
                $display("FAIL pause[%0d]: strobes=%h run=%b, need 0/0", k, strobes, run);
            end
        end
        stop = 1'b0;
        tick();
        n_vec++;
        if (strobes !== F0 || run !== 1'b1) begin
            n_err++;
            $display("FAIL pause_exit: strobes=%h run=%b, need %h/1", strobes, run, F0);
        end
    endtask

    task automatic test_halt;
        ir = 32'hC800_0000;
        for (int k = 0; k < 3; k++) tick();
        for (int k = 0; k < 20; k++) begin
            stop = k[0];
            n_vec++;
            if (strobes !== 28'd0 || run !== 1'b0) begin
                n_err++;
                $display("FAIL halt[%0d]: strobes=%h run=%b, need 0/0", k, strobes, run);
            end
            tick();
        end
        stop = 1'b0;
        ir = 32'hC000_0000;
        clr = 1'b0;
        tick();
        clr = 1'b1;
        tick();
        n_vec++;
        if (strobes !== F0 || run !== 1'b1) begin
            n_err++;
            $display("FAIL halt_restart: strobes=%h run=%b, need %h/1", strobes, run, F0);
        end
    endtask

    initial begin
        test_reset();
        test_sequences();
        test_branch();
        test_reset_mid();
        test_stop_mul();
        test_halt();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Moore-style hardwired sequencer that drives every strobe of the single-bus CPU datapath: register-file select/in/out, special-register in/out, MDR read/write, ALU operation code.
- Runs fetch (T0–T2), then a per-class execute sequence (T3–T7), then returns to T0.
- Sits beside the cpu datapath. Its strobes replace the testbench-driven control wires.

Parameters:
- OPW, 6, width of ALU operation output
- RESET_PC_WAIT, 1, cycles spent in S_RESET before first fetch (1..4)

Ports:
- clk  in  1  system clock, rising edge
- clr  in  1  reset: asynchronous, active-low (clr=0 resets)
- stop  in  1  pause request, level-sensitive
- ir  in  32  IR contents; opcode = ir[31:27]
- con_ff  in  1  branch condition flip-flop output
- run  out  1  1 while executing; 0 in reset, pause, halt
- gra, grb, grc  out  1 each  register-field selects (ir[26:23], ir[22:19], ir[18:15])
- r_in, r_out, ba_out  out  1 each  register-file write / drive / base-address drive
- pc_out, mdr_out, zhigh_out, zlow_out, hi_out, lo_out, inport_out, c_out  out  1 each  bus source strobes
- mar_in, pc_in, mdr_in, ir_in, y_in, hi_in, lo_in, zhigh_in, zlow_in, outport_in, con_in, inc_pc, read, write  out  1 each  load/control strobes
- operation  out  OPW  ALU op; {1'b0, opcode} for ALU-using steps, 6'b0 otherwise

Behaviour:
- Reset (clr=0, any time, mid-instruction included): state=S_RESET; all outputs 0; run=0. After release, stay RESET_PC_WAIT cycles, then T0.
- Outputs are decoded from state and the opcode class only; no output depends combinationally on stop.
- One state per clock. Unlisted strobes are 0.
- Fetch:
  - T0: pc_out, mar_in, inc_pc, zlow_in
  - T1: zlow_out, pc_in, read, mdr_in
  - T2: mdr_out, ir_in
  - ir is valid from T3 onward.
- ALU reg (add, sub, and, or, shr, shl, ror, rol): T3 grb r_out y_in; T4 grc r_out operation zlow_in; T5 zlow_out gra r_in.
- ALU imm (addi, andi, ori): T3 grb r_out y_in; T4 c_out operation zlow_in; T5 zlow_out gra r_in.
- mul/div: T3 gra r_out y_in; T4 grb r_out operation zlow_in zhigh_in; T5 zlow_out lo_in; T6 zhigh_out hi_in.
- neg/not: T3 grb r_out operation zlow_in; T4 zlow_out gra r_in.
- ld: T3 grb ba_out y_in; T4 c_out operation=ADD zlow_in; T5 zlow_out mar_in; T6 read mdr_in; T7 mdr_out gra r_in.
- ldi: T3–T4 as ld; T5 zlow_out gra r_in.
- st: T3–T5 as ld; T6 gra r_out mdr_in (read=0); T7 write.
- br: T3 gra r_out con_in; T4 pc_out y_in; T5 c_out operation=ADD zlow_in; T6 zlow_out pc_in only if con_ff=1, else a dead cycle.
- jr: T3 gra r_out pc_in.
- in: T3 inport_out gra r_in.
- out: T3 gra r_out outport_in.
- mfhi: T3 hi_out gra r_in.
- mflo: T3 lo_out gra r_in.
- nop, and any undefined opcode: return directly to T0 after T2.
- halt: enter S_HALT; run=0, all strobes 0. Only clr exits.
- stop is sampled only at the transition into T0:
  - stop=1 → S_PAUSE (run=0, strobes 0).
  - Leave S_PAUSE for T0 the cycle after stop=0.
  - An in-flight instruction always completes.
- Latency, T0 to next T0: nop 3, jr/in/out/mfhi/mflo 4, neg/not 5, ALU/ldi 6, mul/div/br 7, ld/st 8 cycles.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - opcode constants: ld 00000, ldi 00001, st 00010, add 00011, sub 00100, and 00101, or 00110, shr 00111, shl 01000, ror 01001, rol 01010, addi 01011, andi 01100, ori 01101, mul 01110, div 01111, neg 10000, not 10001, br 10010, jr 10011, in 10100, out 10101, mfhi 10110, mflo 10111, nop 11000, halt 11001
  - state enum: S_RESET, S_T0..S_T7, S_PAUSE, S_HALT
  - op-class enum and OP_ADD
- One sub-module, ctrl_op_decode: combinational opcode → op-class.

Test Plan:
- Reset → clr=0 for 2 cycles mid-T4 of an add → all outputs 0 and run=0 immediately; after release, T0 strobes (pc_out, mar_in, inc_pc, zlow_in) appear after RESET_PC_WAIT cycles.
- add (ir=0x18A00000, opcode 00011) → T3 grb/r_out/y_in, T4 grc/r_out/zlow_in with operation=6'h03, T5 zlow_out/gra/r_in, then T0; 6 cycles total.
- ld (opcode 00000) → read=1 and mdr_in=1 only in T1 and T6; write never asserted; 8 cycles.
- st → read=0 in T6, write=1 exactly one cycle in T7.
- br with con_ff=0 → pc_in is never asserted after T1; with con_ff=1 → pc_in asserted in T6; 7 cycles either way.
- stop asserted during T4 of mul → T5 and T6 complete (lo_in, then hi_in), then S_PAUSE with run=0; stop released → T0 on the following cycle.
- halt (opcode 11001) → run=0 held for 20 cycles; stop toggling has no effect; clr pulse restarts fetch.
